sc_bitstream_decoder: RTL and testbench

- Converts a unary stochastic bitstream back to binary: counts ones over a fixed window of 2^BITWIDTH enabled cycles.
- Is the receive end of the team's Sobol-based stream generators; sits at the output of scaled SC arithmetic (e.g. SFFT butterflies) before binary post-processing.
- Delivers one result per window through a valid/ready register, with a sticky overrun flag.

---
 rtl/sc_pkg.sv | 25 ++
 rtl/sc_bitstream_decoder_if.sv | 21 ++
 rtl/sc_bitstream_decoder_win_cnt.sv | 27 ++
 rtl/sc_bitstream_decoder.sv | 92 +++++++++
 tb/tb_sc_bitstream_decoder.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/sc_pkg.sv
// Shared constants and helpers for the stochastic-computing blocks.
// Window length, saturation limits and bipolar offset as functions of width.
package sc_pkg;

  function automatic int unsigned winLen(input int unsigned bw);
    return 32'd1 << bw;
  endfunction

  function automatic int unsigned uniMax(input int unsigned bw);
    return winLen(bw) - 32'd1;
  endfunction

  function automatic int unsigned bipOffset(input int unsigned bw);
    return winLen(bw) >> 1;
  endfunction

  function automatic int bipMax(input int unsigned bw);
    return int'(bipOffset(bw)) - 1;
  endfunction

  function automatic int bipMin(input int unsigned bw);
    return -int'(bipOffset(bw));
  endfunction

endpackage

// File: rtl/sc_bitstream_decoder_if.sv
// Result handshake bundle of the stochastic bitstream decoder.
// master drives the result; slave consumes it and drives iReady.
interface sc_bitstream_decoder_if #(
  parameter int BITWIDTH = 8
);
  logic [BITWIDTH-1:0] oData;
  logic                oValid;
  logic                iReady;
  logic                oOvf;
  logic                oBusy;

  modport master (
    output oData, oValid, oOvf, oBusy,
    input  iReady
  );

  modport slave (
    input  oData, oValid, oOvf, oBusy,
    output iReady
  );
endinterface

// File: rtl/sc_bitstream_decoder_win_cnt.sv
// Window counter for the bitstream decoder (module sc_win_cnt).
// Wrap strobe is combinational: enabled sample at the all-ones count.
module sc_win_cnt #(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iClr,
  output logic [BITWIDTH-1:0] oCnt,
  output logic                oWrap
);

  // Advance on enabled samples, wrapping naturally at 2^BITWIDTH.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oCnt <= '0;
    end else if (iClr) begin
      oCnt <= '0;
    end else if (iEn) begin
      oCnt <= oCnt + 1'b1;
    end
  end

  assign oWrap = iEn && (&oCnt);

endmodule

// File: rtl/sc_bitstream_decoder.sv
// Stochastic bitstream decoder: counts ones over 2^BITWIDTH enabled cycles.
// Define SC_DECODER_BIPOLAR_EN for two's-complement bipolar output.
module sc_bitstream_decoder
  import sc_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iEn,
  input  logic iClr,
  input  logic iBit,
  sc_bitstream_decoder_if.master bus
);

  logic [BITWIDTH-1:0] winCnt;
  logic                winEnd;
  logic [BITWIDTH:0]   onesCnt;
  logic [BITWIDTH:0]   total;
  logic [BITWIDTH-1:0] dec;
  logic [BITWIDTH-1:0] dataQ;
  logic                validQ;
  logic                ovfQ;
  logic                xfer;

  sc_win_cnt #(
    .BITWIDTH(BITWIDTH)
  ) uWinCnt (
    .iClk (iClk),
    .iRst (iRst),
    .iEn  (iEn),
    .iClr (iClr),
    .oCnt (winCnt),
    .oWrap(winEnd)
  );

  assign total = onesCnt + {{BITWIDTH{1'b0}}, iBit};
  assign xfer  = validQ && bus.iReady;

`ifdef SC_DECODER_BIPOLAR_EN
  localparam logic [BITWIDTH:0] Off =
    (BITWIDTH+1)'(bipOffset(BITWIDTH));
  localparam logic [BITWIDTH-1:0] BipHi =
    BITWIDTH'(bipMax(BITWIDTH));

  // Offset by N/2; only total == N exceeds the positive limit.
  always_comb begin
    dec = BITWIDTH'(total - Off);
    if (total[BITWIDTH]) dec = BipHi;
  end
`else
  localparam logic [BITWIDTH-1:0] UniHi =
    BITWIDTH'(uniMax(BITWIDTH));

  // Saturate the single overflow case total == N to N-1.
  always_comb begin
    dec = total[BITWIDTH-1:0];
    if (total[BITWIDTH]) dec = UniHi;
  end
`endif

  // Accumulate ones; load result and manage valid/overrun at window end.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      onesCnt <= '0;
      dataQ   <= '0;
      validQ  <= 1'b0;
      ovfQ    <= 1'b0;
    end else if (iClr) begin
      onesCnt <= '0;
      validQ  <= 1'b0;
      ovfQ    <= 1'b0;
    end else begin
      if (iEn) begin
        onesCnt <= winEnd ? '0 : total;
      end
      if (winEnd) begin
        dataQ  <= dec;
        validQ <= 1'b1;
        if (validQ && !bus.iReady) ovfQ <= 1'b1;
      end else if (xfer) begin
        validQ <= 1'b0;
      end
    end
  end

  assign bus.oData  = dataQ;
  assign bus.oValid = validQ;
  assign bus.oOvf   = ovfQ;
  assign bus.oBusy  = (winCnt != '0);

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// Bench for sc_bitstream_decoder: behavioural model plus result scoreboard.
// Build with SC_DECODER_BIPOLAR_EN to exercise the bipolar variant.
module tb_sc_bitstream_decoder;
  import sc_pkg::*;

  localparam int BW = 8;
  localparam int N  = 256;

`ifdef SC_DECODER_BIPOLAR_EN
  localparam int OnesExp = 8'h7f;
  localparam int ZeroExp = 8'h80;
  localparam int SobExp  = 8'he4;
  localparam int QtrExp  = 8'hc0;
`else
  localparam int OnesExp = 255;
  localparam int ZeroExp = 0;
  localparam int SobExp  = 100;
  localparam int QtrExp  = 64;
`endif

  logic clk = 1'b0;
  logic rst, en, clr, bitIn;

  always #5 clk = ~clk;

  sc_bitstream_decoder_if #(.BITWIDTH(BW)) bus ();

  sc_bitstream_decoder #(
    .BITWIDTH(BW)
  ) dut (
    .iClk(clk),
    .iRst(rst),
    .iEn (en),
    .iClr(clr),
    .iBit(bitIn),
    .bus (bus)
  );

  int nChk  = 0;
  int nPass = 0;
  int q[$];
  int mWin  = 0;
  int mOnes = 0;
  bit mOvf  = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic int expF(int total);
    int v;
`ifdef SC_DECODER_BIPOLAR_EN
    v = total - N / 2;
    if (v > N / 2 - 1) v = N / 2 - 1;
    if (v < -N / 2) v = -N / 2;
    return v & (N - 1);
`else
    v = total;
    if (v > N - 1) v = N - 1;
    return v;
`endif
  endfunction

  function automatic int bitRev(int x);
    int r;
    r = 0;
    for (int k = 0; k < BW; k++) r = (r << 1) | ((x >> k) & 1);
    return r;
  endfunction

  task automatic checkOut();
    chk("valid", 32'(bus.oValid), 32'(q.size() > 0));
    chk("ovf", 32'(bus.oOvf), 32'(mOvf));
    chk("busy", 32'(bus.oBusy), 32'(mWin != 0));
    if (q.size() > 0) chk("data", 32'(bus.oData), 32'(q[0]));
  endtask

  task automatic step(bit e, bit b, bit r, bit c);
    bit xfer;
    int v;
    checkOut();
    en = e;
    bitIn = b;
    bus.iReady = r;
    clr = c;
    xfer = (q.size() > 0) && r;
    if (c) begin
      mWin = 0;
      mOnes = 0;
      q.delete();
      mOvf = 0;
    end else begin
      if (xfer) void'(q.pop_front());
      if (e) begin
        if (mWin == N - 1) begin
          v = expF(mOnes + int'(b));
          if (q.size() > 0) begin
            mOvf = 1;
            q.delete();
          end
          q.push_back(v);
          mOnes = 0;
          mWin = 0;
        end else begin
          mOnes += int'(b);
          mWin++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic modelRst();
    mWin = 0;
    mOnes = 0;
    mOvf = 0;
    q.delete();
  endtask

  task automatic chkRst(string tag);
    chk({tag, "_data"}, 32'(bus.oData), 32'd0);
    chk({tag, "_valid"}, 32'(bus.oValid), 32'd0);
    chk({tag, "_ovf"}, 32'(bus.oOvf), 32'd0);
    chk({tag, "_busy"}, 32'(bus.oBusy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    clr = 1'b0;
    bitIn = 1'b0;
    bus.iReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    modelRst();
    chkRst("reset");

    // all ones, two back-to-back windows
    for (int i = 0; i < 255; i++) step(1, 1, 1, 0);
    chk("t1_novalid", 32'(bus.oValid), 32'd0);
    step(1, 1, 1, 0);
    chk("t1_valid", 32'(bus.oValid), 32'd1);
    chk("t1_data", 32'(bus.oData), 32'(OnesExp));
    for (int i = 0; i < 256; i++) step(1, 1, 1, 0);
    chk("t1_valid2", 32'(bus.oValid), 32'd1);
    chk("t1_data2", 32'(bus.oData), 32'(OnesExp));

    // low-discrepancy stream compared against 100
    for (int i = 0; i < 256; i++) step(1, bitRev(i) < 100, 1, 0);
    chk("t2_valid", 32'(bus.oValid), 32'd1);
    chk("t2_data", 32'(bus.oData), 32'(SobExp));

    // enable toggling every cycle
    for (int i = 0; i < 511; i++) begin
      step(i % 2 == 0, 1, 1, 0);
      if (i == 1) chk("t3_busy", 32'(bus.oBusy), 32'd1);
    end
    chk("t3_valid", 32'(bus.oValid), 32'd1);
    chk("t3_data", 32'(bus.oData), 32'(OnesExp));
    step(0, 1, 1, 0);

    // overrun with consumer stalled
    for (int i = 0; i < 256; i++) step(1, 0, 0, 0);
    chk("t4_valid1", 32'(bus.oValid), 32'd1);
    chk("t4_data1", 32'(bus.oData), 32'(ZeroExp));
    chk("t4_noovf", 32'(bus.oOvf), 32'd0);
    for (int i = 0; i < 256; i++) step(1, 0, 0, 0);
    chk("t4_ovf", 32'(bus.oOvf), 32'd1);
    chk("t4_valid2", 32'(bus.oValid), 32'd1);
    step(0, 0, 1, 0);
    chk("t4_drain", 32'(bus.oValid), 32'd0);
    chk("t4_ovfkeep", 32'(bus.oOvf), 32'd1);
    step(0, 0, 0, 1);
    chk("t4_clr", 32'(bus.oOvf), 32'd0);

    // clear on the window-end edge
    for (int i = 0; i < 255; i++) step(1, 1, 1, 0);
    step(1, 1, 1, 1);
    chk("t5_valid", 32'(bus.oValid), 32'd0);
    chk("t5_busy", 32'(bus.oBusy), 32'd0);
    for (int i = 0; i < 256; i++) step(1, 1, 1, 0);
    chk("t5_valid2", 32'(bus.oValid), 32'd1);
    chk("t5_data", 32'(bus.oData), 32'(OnesExp));

    // reset mid-window with a pending result
    for (int i = 0; i < 256; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 100; i++) step(1, 0, 0, 0);
    checkOut();
    chk("t6_pre", 32'(bus.oValid), 32'd1);
    rst = 1'b1;
    en = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr = 1'b0;
    modelRst();
    chkRst("t6_rst");
    for (int i = 0; i < 256; i++) step(1, i % 4 == 0, 1, 0);
    chk("t6_valid", 32'(bus.oValid), 32'd1);
    chk("t6_data", 32'(bus.oData), 32'(QtrExp));
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    checkOut();

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
